// File: rtl/ycrcb_pixel_sched.sv
// ycrcb_pixel_sched
// Feeds a shared, externally registered YCrCb->RGB converter from packed
// two-pixel memory words and collects the converted pixels in a small,
// credit-protected output FIFO tagged with line/frame markers.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   start / busy / done frame control: start pulse, busy level, done pulse
//   in_word/in_valid/in_ready
//                       36-bit word {pixel0, pixel1}; pixel = {y8, cr5, cb5}
//   conv_y/cb/cr        pixel presented to the converter (neutral when idle)
//   conv_r/g/b          converter result, CONV_LATENCY cycles later
//   out_rgb/out_eol/out_eof/out_valid/out_ready
//                       FIFO head with markers, popped on valid && ready
module ycrcb_pixel_sched #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int CONV_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [35:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  conv_y,
    output logic [7:0]  conv_cb,
    output logic [7:0]  conv_cr,
    input  logic [7:0]  conv_r,
    input  logic [7:0]  conv_g,
    input  logic [7:0]  conv_b,
    output logic [23:0] out_rgb,
    output logic        out_eol,
    output logic        out_eof,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int TW    = $clog2(TOTAL + 2);
    localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int L     = CONV_LATENCY;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    logic            busy_r;
    logic            done_r;

    // mask_r[1] = pixel0 pending, mask_r[0] = pixel1 pending
    logic [35:0]     hold_r;
    logic [1:0]      mask_r;
    logic [TW-1:0]   acc_cnt_r;
    logic [TW-1:0]   iss_cnt_r;
    logic [XW-1:0]   x_r;
    logic [YW-1:0]   y_r;

    logic [L-1:0]    sr_v_r;
    logic [L-1:0]    sr_eol_r;
    logic [L-1:0]    sr_eof_r;

    logic [25:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   cnt_r;

    logic [CW-1:0]   inflight_s;
    logic [CW:0]     credit_s;
    logic            issue_s;
    logic            accept_s;
    logic            in_ready_s;
    logic [17:0]     pix_s;
    logic            eol_s;
    logic            eof_s;
    logic            last_issue_s;
    logic            push_s;
    logic            pop_s;
    logic [25:0]     head_s;

    // Number of pixels currently travelling through the converter.
    function automatic logic [CW-1:0] popcount(input logic [L-1:0] v);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < L; i++) begin
            if (v[i]) begin
                n = n + CW'(1'b1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Issue decision: credits count FIFO entries plus in-flight pixels and
    // ignore a same-cycle pop, so the FIFO can never be pushed while full.
    always_comb begin
        inflight_s   = popcount(sr_v_r);
        credit_s     = {1'b0, cnt_r} + {1'b0, inflight_s};
        issue_s      = (state_r == RUN) && (mask_r != 2'b00) &&
                       (credit_s < (CW+1)'(FIFO_DEPTH));
        pix_s        = mask_r[1] ? hold_r[35:18] : hold_r[17:0];
        eol_s        = (x_r == XW'(H_ACTIVE - 1));
        eof_s        = eol_s && (y_r == YW'(V_ACTIVE - 1));
        last_issue_s = issue_s && (iss_cnt_r == TW'(TOTAL - 1));
    end

    // Input handshake: a new word is taken only once the hold register is
    // free (or its last pixel leaves this cycle) and the frame still needs it.
    always_comb begin
        in_ready_s = 1'b0;
        if ((state_r == RUN) && (acc_cnt_r < TW'(TOTAL))) begin
            in_ready_s = (mask_r == 2'b00) || ((mask_r == 2'b01) && issue_s);
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Converter drive: chroma widened by zero-fill, neutral black when idle.
    always_comb begin
        conv_y  = 8'd16;
        conv_cb = 8'd128;
        conv_cr = 8'd128;
        if (issue_s) begin
            conv_y  = pix_s[17:10];
            conv_cr = {pix_s[9:5], 3'b000};
            conv_cb = {pix_s[4:0], 3'b000};
        end else begin
            conv_y  = 8'd16;
            conv_cb = 8'd128;
            conv_cr = 8'd128;
        end
    end

    // FIFO head presentation; markers and data are masked when empty.
    always_comb begin
        push_s    = sr_v_r[L-1];
        pop_s     = (cnt_r != {CW{1'b0}}) && out_ready;
        head_s    = mem_r[rd_ptr_r];
        out_valid = (cnt_r != {CW{1'b0}});
        if (out_valid) begin
            out_eol = head_s[25];
            out_eof = head_s[24];
            out_rgb = head_s[23:0];
        end else begin
            out_eol = 1'b0;
            out_eof = 1'b0;
            out_rgb = 24'd0;
        end
    end

    assign in_ready = in_ready_s;
    assign busy     = busy_r;
    assign done     = done_r;

    // Frame control FSM: IDLE -> RUN on start, DRAIN after the last issue,
    // back to IDLE with a done pulse once converter and FIFO are empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_issue_s) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((inflight_s == {CW{1'b0}}) && (cnt_r == {CW{1'b0}})) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Hold register, pending mask and frame position counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_r    <= 36'd0;
            mask_r    <= 2'b00;
            acc_cnt_r <= {TW{1'b0}};
            iss_cnt_r <= {TW{1'b0}};
            x_r       <= {XW{1'b0}};
            y_r       <= {YW{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            mask_r    <= 2'b00;
            acc_cnt_r <= {TW{1'b0}};
            iss_cnt_r <= {TW{1'b0}};
            x_r       <= {XW{1'b0}};
            y_r       <= {YW{1'b0}};
        end else begin
            if (accept_s) begin
                hold_r    <= in_word;
                mask_r    <= 2'b11;
                acc_cnt_r <= acc_cnt_r + TW'(2);
            end else if (issue_s) begin
                mask_r <= mask_r[1] ? {1'b0, mask_r[0]} : 2'b00;
            end
            if (issue_s) begin
                iss_cnt_r <= iss_cnt_r + TW'(1);
                if (eol_s) begin
                    x_r <= {XW{1'b0}};
                    y_r <= eof_s ? {YW{1'b0}} : (y_r + YW'(1));
                end else begin
                    x_r <= x_r + XW'(1);
                end
            end
            // An odd pixel total leaves an unused half word behind.
            if (last_issue_s) begin
                mask_r <= 2'b00;
            end
        end
    end

    // In-flight tracker matching the converter latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            sr_v_r   <= {L{1'b0}};
            sr_eol_r <= {L{1'b0}};
            sr_eof_r <= {L{1'b0}};
        end else begin
            sr_v_r[0]   <= issue_s;
            sr_eol_r[0] <= issue_s && eol_s;
            sr_eof_r[0] <= issue_s && eof_s;
            for (int i = 1; i < L; i++) begin
                sr_v_r[i]   <= sr_v_r[i-1];
                sr_eol_r[i] <= sr_eol_r[i-1];
                sr_eof_r[i] <= sr_eof_r[i-1];
            end
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 26'd0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {sr_eol_r[L-1], sr_eof_r[L-1], conv_r, conv_g, conv_b};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_ycrcb_pixel_sched.sv
// Scoreboard bench for ycrcb_pixel_sched with a small frame (4x2).
module tb_ycrcb_pixel_sched;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int D    = 4;
    localparam int NPIX = H * V;
    localparam int NWRD = NPIX / 2;

    logic        clock = 1'b0;
    logic        reset, start, in_valid, out_ready;
    logic [35:0] in_word;
    logic        busy, done, in_ready, out_eol, out_eof, out_valid;
    logic [7:0]  conv_y, conv_cb, conv_cr, conv_r, conv_g, conv_b;
    logic [23:0] out_rgb;

    ycrcb_pixel_sched #(.H_ACTIVE(H), .V_ACTIVE(V), .CONV_LATENCY(1), .FIFO_DEPTH(D)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .conv_y(conv_y), .conv_cb(conv_cb), .conv_cr(conv_cr),
        .conv_r(conv_r), .conv_g(conv_g), .conv_b(conv_b),
        .out_rgb(out_rgb), .out_eol(out_eol), .out_eof(out_eof),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    // Reference converter: BT.601-like integer approximation with saturation.
    function automatic logic [23:0] cvt(input int y, input int cb, input int cr);
        int c[3];
        c[0] = y + ((359 * (cr - 128)) >>> 8);
        c[1] = y - ((88 * (cb - 128) + 183 * (cr - 128)) >>> 8);
        c[2] = y + ((454 * (cb - 128)) >>> 8);
        for (int i = 0; i < 3; i++) begin
            if (c[i] < 0) c[i] = 0;
            if (c[i] > 255) c[i] = 255;
        end
        return {c[0][7:0], c[1][7:0], c[2][7:0]};
    endfunction

    // Converter stand-in, one registered stage.
    always @(posedge clock) begin
        {conv_r, conv_g, conv_b} <= cvt(int'(conv_y), int'(conv_cb), int'(conv_cr));
    end

    typedef struct { logic [23:0] rgb; logic eol; logic eof; } exp_t;
    typedef struct { int y; int cr; int cb; } iss_t;
    exp_t exp_q[$];
    iss_t iss_q[$];

    int checks = 0, errors = 0;
    int frame_pix, words_acc, issued, popped, done_cnt, rdy_mode;
    exp_t m_e;
    iss_t m_i;
    logic [17:0] m_p;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (event missing or bound expired)", name);
    endtask

    function automatic logic [17:0] rand_pix();
        logic [7:0] y;
        logic [4:0] cr, cb;
        y  = 8'($urandom_range(255, 17));
        cr = 5'($urandom_range(31, 0));
        cb = 5'($urandom_range(31, 0));
        return {y, cr, cb};
    endfunction

    // Monitor: predicts on accepted words, checks issued pixels and pops.
    always @(negedge clock) begin
        if (!reset) begin
            if (conv_y !== 8'd16 || conv_cr !== 8'd128 || conv_cb !== 8'd128) begin
                issued++;
                if (iss_q.size() == 0) begin
                    fail("spurious_issue");
                end else begin
                    m_i = iss_q.pop_front();
                    chk("conv_y", conv_y, m_i.y);
                    chk("conv_cr", conv_cr, m_i.cr);
                    chk("conv_cb", conv_cb, m_i.cb);
                end
            end
            if (in_valid && in_ready) begin
                words_acc++;
                for (int j = 0; j < 2; j++) begin
                    m_p    = (j == 0) ? in_word[35:18] : in_word[17:0];
                    m_i.y  = int'(m_p[17:10]);
                    m_i.cr = int'(m_p[9:5]) * 8;
                    m_i.cb = int'(m_p[4:0]) * 8;
                    iss_q.push_back(m_i);
                    m_e.rgb = cvt(m_i.y, m_i.cb, m_i.cr);
                    m_e.eol = ((frame_pix % H) == H - 1);
                    m_e.eof = (frame_pix == NPIX - 1);
                    exp_q.push_back(m_e);
                    frame_pix++;
                end
            end
            if (out_valid && out_ready) begin
                popped++;
                if (exp_q.size() == 0) begin
                    fail("spurious_pop");
                end else begin
                    m_e = exp_q.pop_front();
                    chk("out_rgb", out_rgb, m_e.rgb);
                    chk("out_eol", out_eol, m_e.eol);
                    chk("out_eof", out_eof, m_e.eof);
                end
            end
            if (!out_valid) begin
                chk("eol_idle", out_eol, 1'b0);
                chk("eof_idle", out_eof, 1'b0);
            end
            chk("credit", ((issued - popped) <= D), 1'b1);
            if (done) done_cnt++;
        end
    end

    // Output-side backpressure driver.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(99) < 60);
            endcase
        end
    end

    task automatic begin_frame();
        frame_pix = 0; words_acc = 0; issued = 0; popped = 0; done_cnt = 0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [35:0] w, input int gap_pct);
        int budget;
        logic acc;
        budget = 2000;
        acc = 1'b0;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clock); #1;
        end
        in_word  = w;
        in_valid = 1'b1;
        while (!acc && budget > 0) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock); #1;
            budget--;
        end
        if (!acc) fail("send_timeout");
        in_valid = 1'b0;
    endtask

    task automatic send_words(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) send_word({rand_pix(), rand_pix()}, gap_pct);
    endtask

    task automatic finish_frame(input string tag);
        int budget;
        budget = 600;
        while (done_cnt == 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (done_cnt == 0) fail({tag, "_done_timeout"});
        repeat (3) @(negedge clock);
        in_word  = {rand_pix(), rand_pix()};
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk({tag, "_post_ready"}, in_ready, 1'b0);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_busy_low"}, busy, 1'b0);
        chk({tag, "_pix_out"}, popped, NPIX);
        chk({tag, "_words"}, words_acc, NWRD);
        chk({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_word = 36'd0; rdy_mode = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_rgb", out_rgb, 24'd0);
        chk("rst_conv_y", conv_y, 8'd16);
        chk("rst_conv_cb", conv_cb, 8'd128);
        chk("rst_conv_cr", conv_cr, 8'd128);
        @(posedge clock); #1;
        reset = 1'b0;

        // Latency of the first word into an empty pipe.
        begin_frame();
        in_word  = {8'd255, 5'd16, 5'd16, rand_pix()};
        in_valid = 1'b1;
        @(negedge clock);
        chk("t1_accept", in_ready, 1'b1);
        chk("t1_busy", busy, 1'b1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("t1_conv_y", conv_y, 8'd255);
        chk("t1_conv_cr", conv_cr, 8'd128);
        chk("t1_conv_cb", conv_cb, 8'd128);
        @(negedge clock);
        chk("t1_early_valid", out_valid, 1'b0);
        @(negedge clock);
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_rgb", out_rgb, 24'hFFFFFF);
        chk("t1_eol", out_eol, 1'b0);
        @(posedge clock); #1;
        send_words(NWRD - 1, 30);
        finish_frame("t1");

        // Backpressure: only FIFO_DEPTH pixels may be issued.
        rdy_mode = 0;
        @(posedge clock); #1;
        begin_frame();
        fork
            send_words(NWRD, 0);
            begin
                repeat (20) @(negedge clock);
                chk("bp_issued", issued, D);
                rdy_mode = 1;
            end
        join
        finish_frame("t2");

        // Random handshakes, ignored start, full-scale chroma.
        rdy_mode = 2;
        begin_frame();
        send_word({8'($urandom_range(255, 17)), 5'd31, 5'd0, rand_pix()}, 0);
        @(negedge clock);
        chk("sat_cr", conv_cr, 8'd248);
        chk("sat_cb", conv_cb, 8'd0);
        @(posedge clock); #1;
        send_words(1, 40);
        pulse_start();
        send_words(NWRD - 2, 40);
        finish_frame("t3");

        // Reset with a full FIFO, then a clean frame.
        rdy_mode = 0;
        @(posedge clock); #1;
        begin_frame();
        send_words(2, 0);
        repeat (6) @(posedge clock);
        @(negedge clock);
        chk("t4_full_valid", out_valid, 1'b1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("t4_out_valid", out_valid, 1'b0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_in_ready", in_ready, 1'b0);
        chk("t4_conv_y", conv_y, 8'd16);
        chk("t4_conv_cb", conv_cb, 8'd128);
        chk("t4_conv_cr", conv_cr, 8'd128);
        exp_q.delete();
        iss_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        rdy_mode = 2;
        begin_frame();
        send_words(NWRD, 30);
        finish_frame("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
